eeprom_store: RTL

//   Backing store for the cartridge EEPROM protocol engine: 8 KiB byte memory

---
 rtl/eeprom_store.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/eeprom_store.sv
// Cartridge EEPROM backing store: 8 KiB byte memory for the protocol engine,
// loaded from and written back to the SD image in 512-byte sectors.
module eeprom_store #(
  parameter logic [23:0] AUTOSAVE_DELAY = 24'd8_000_000,
  parameter int unsigned NUM_SECTORS    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ee_req,
  input  logic        ee_we,
  input  logic [12:0] ee_addr,
  input  logic [7:0]  ee_wdata,
  output logic [7:0]  ee_rdata,
  output logic        ee_ack,
  input  logic        img_mounted,
  input  logic        save_trigger,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  output logic        loading
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, SAVE_SCAN, SAVE_REQ, SAVE_WAIT
  } state_t;

  state_t      state, state_n;
  logic [3:0]  sector, sector_n, scan_idx;
  logic        scan_found;
  logic        loading_n;
  logic [15:0] dirty, dirty_n, dirty_set, dirty_clr;
  logic        dirty_wipe, save_start, mount_take, mount_pend;
  logic [23:0] idle_cnt;
  logic        mount_d, trig_d, mount_rise, save_rise, mount_go, saving;

  logic        pend_valid, pend_we;
  logic [12:0] pend_addr;
  logic [7:0]  pend_wdata;
  logic        acc_valid, acc_we;
  logic [12:0] acc_addr;
  logic [7:0]  acc_wdata;

  logic        load_wr;
  logic [11:0] row_b;
  logic [7:0]  mem_even [0:4095];
  logic [7:0]  mem_odd  [0:4095];

  assign mount_rise = img_mounted & ~mount_d;
  assign save_rise  = save_trigger & ~trig_d;
  assign mount_go   = mount_rise | mount_pend;
  assign saving     = (state == SAVE_SCAN) || (state == SAVE_REQ) || (state == SAVE_WAIT);

  assign sd_rd  = (state == LOAD_REQ);
  assign sd_wr  = (state == SAVE_REQ);
  assign sd_lba = {28'd0, sector};
  assign row_b  = {sector, sd_buff_addr};

  // A request held during the load takes the engine slot once loading drops.
  assign acc_valid = !loading && (pend_valid || ee_req);
  assign acc_we    = pend_valid ? pend_we    : ee_we;
  assign acc_addr  = pend_valid ? pend_addr  : ee_addr;
  assign acc_wdata = pend_valid ? pend_wdata : ee_wdata;

  assign load_wr   = sd_ack && sd_buff_wr && ((state == LOAD_REQ) || (state == LOAD_WAIT));
  assign dirty_set = (acc_valid && acc_we) ? (16'd1 << acc_addr[12:9]) : '0;
  assign dirty_n   = dirty_wipe ? '0 : ((dirty & ~dirty_clr) | dirty_set);

  always_comb begin
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!scan_found && dirty[i]) begin
        scan_idx   = 4'(i);
        scan_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    sector_n   = sector;
    loading_n  = loading;
    dirty_clr  = '0;
    dirty_wipe = 1'b0;
    save_start = 1'b0;
    mount_take = 1'b0;
    case (state)
      IDLE: begin
        if (mount_go) begin
          state_n    = LOAD_REQ;
          sector_n   = '0;
          loading_n  = 1'b1;
          mount_take = 1'b1;
        end else if ((save_rise || idle_cnt == AUTOSAVE_DELAY) && dirty != '0) begin
          state_n    = SAVE_SCAN;
          save_start = 1'b1;
        end
      end
      LOAD_REQ:  if (sd_ack) state_n = LOAD_WAIT;
      LOAD_WAIT: begin
        if (!sd_ack) begin
          if (sector == 4'(NUM_SECTORS - 1)) begin
            state_n    = IDLE;
            loading_n  = 1'b0;
            dirty_wipe = 1'b1;
          end else begin
            sector_n = sector + 4'd1;
            state_n  = LOAD_REQ;
          end
        end
      end
      SAVE_SCAN: begin
        sector_n  = scan_idx;
        dirty_clr = 16'd1 << scan_idx;
        state_n   = SAVE_REQ;
      end
      SAVE_REQ:  if (sd_ack) state_n = SAVE_WAIT;
      SAVE_WAIT: begin
        if (!sd_ack) begin
          if (mount_go) begin
            state_n    = LOAD_REQ;
            sector_n   = '0;
            loading_n  = 1'b1;
            mount_take = 1'b1;
          end else if ((dirty | dirty_set) != '0) begin
            state_n = SAVE_SCAN;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sector      <= '0;
      loading     <= 1'b0;
      dirty       <= '0;
      idle_cnt    <= '0;
      mount_d     <= 1'b0;
      trig_d      <= 1'b0;
      mount_pend  <= 1'b0;
      pend_valid  <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      ee_ack      <= 1'b0;
      ee_rdata    <= '0;
      sd_buff_din <= '0;
    end else begin
      state      <= state_n;
      sector     <= sector_n;
      loading    <= loading_n;
      dirty      <= dirty_n;
      mount_d    <= img_mounted;
      trig_d     <= save_trigger;
      mount_pend <= (mount_pend | (mount_rise & saving)) & ~mount_take;

      if ((dirty_set != '0) || save_start)
        idle_cnt <= '0;
      else if (idle_cnt != AUTOSAVE_DELAY)
        idle_cnt <= idle_cnt + 24'd1;

      if (loading && ee_req && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_we    <= ee_we;
        pend_addr  <= ee_addr;
        pend_wdata <= ee_wdata;
      end else if (acc_valid) begin
        pend_valid <= 1'b0;
      end

      ee_ack <= acc_valid;
      if (acc_valid && !acc_we)
        ee_rdata <= acc_addr[0] ? mem_odd[acc_addr[12:1]] : mem_even[acc_addr[12:1]];

      if (state == SAVE_WAIT)
        sd_buff_din <= {mem_odd[row_b], mem_even[row_b]};
    end
  end

  // Engine is held off while loading, so the load and engine writes never collide.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      mem_even[row_b] <= sd_buff_dout[7:0];
      mem_odd[row_b]  <= sd_buff_dout[15:8];
    end else if (acc_valid && acc_we) begin
      if (acc_addr[0]) mem_odd[acc_addr[12:1]]  <= acc_wdata;
      else             mem_even[acc_addr[12:1]] <= acc_wdata;
    end
  end

endmodule
